instr_index_sequencer: RTL and testbench
========================================

Name: instr_index_sequencer

Overview:
Index generator on the other end of the instruction buffer's index/start interface. It drives `buffer_index` sequentially while the buffer fills, then switches to mapping-table-driven indices once the buffer asserts `start`. It continues to drain all `bs` slots after the instruction stream ends, then signals `done`. Sits between the ESM control path and the instruction buffer, which reads and writes the same slot each cycle.

Parameters:
bs, 16, instruction buffer depth in entries; power of two, >= 2
IW, $clog2(bs), index width (derived, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
en  input  1  advance enable; 0 freezes all state and outputs
start_i  input  1  `start` from the instruction buffer (buffer full, or stream ended)
instr_done  input  1  instruction stream exhausted (Instr_in == 0 at buffer input)
map_we  input  1  mapping-table write strobe
map_waddr  input  IW  mapping-table write address
map_wdata  input  IW  mapping-table write data (target buffer slot)
buffer_index  output  IW  slot index to the instruction buffer, registered
out_valid  output  1  1 when the buffer's Instr_out produced by the current index is a real reordered instruction
done  output  1  sticky; all slots drained
map_err  output  1  illegal mapping write flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; buffer_index=0; out_valid=0; done=0; map_err=0.
  - Map pointer mp=0; drain counter dc=0.
  - Mapping table reset to identity: map[i]=i.
- Every transition below requires en=1. With en=0, all registers hold, and table writes still apply only in IDLE or FILL.
- States: IDLE, FILL, MAP, DRAIN, DONE.
- IDLE:
  - buffer_index holds 0.
  - Next cycle → FILL, buffer_index <= 1.
- FILL:
  - buffer_index <= buffer_index+1, wrapping bs-1 → 0; out_valid=0.
  - When start_i=1 is sampled: → MAP, buffer_index <= map[0], mp <= 1.
- MAP:
  - Each cycle: buffer_index <= map[mp]; mp <= mp+1, wrapping to 0 after bs-1.
  - out_valid <= 1 from the first MAP cycle onward.
  - When instr_done=1 is sampled: → DRAIN, dc <= bs-1. The index for that cycle is still issued from map[mp].
- DRAIN:
  - Same index generation as MAP; dc decrements per cycle.
  - When dc=0: → DONE.
  - Exactly bs indices are issued after instr_done is sampled, counting the transition cycle.
- DONE:
  - buffer_index holds its last value; out_valid <= 0; done <= 1 (sticky until reset).
  - start_i and instr_done are ignored.
- Simultaneous start_i and instr_done in FILL: → MAP on that edge; instr_done is evaluated on the next cycle. The producer holds instr_done high once the stream ends.
- instr_done=1 while still in FILL (fewer instructions than bs): the buffer raises start_i in the same cycle, so the rule above applies.
- Mapping table:
  - bs x IW registers.
  - Writes are accepted only in IDLE and FILL, and take effect on the next edge.
  - A read in the same cycle as a write to the same address returns the old value.
  - Writes in MAP, DRAIN or DONE are ignored; the table is unchanged.
- The table content is not checked for being a permutation. Duplicate entries produce duplicate slot reads, which is the software's responsibility.
- Reset mid-operation: immediate return to IDLE and an identity table. The in-flight index is discarded.

Optional Feature:
- INSTR_MAP_ERR_EN defined:
  - map_err is set (sticky until reset) on any map_we=1 sampled in MAP, DRAIN or DONE.
  - map_err is also set if map_waddr or map_wdata is >= bs. For non-power-of-two bs this write is also ignored.
- INSTR_MAP_ERR_EN undefined: map_err is tied to 0 and no checking logic is synthesized. Illegal writes are silently ignored as above.

Test Plan:
- Reset/identity: bs=4, rst low then high, en=1, start_i asserted at cycle 5 → buffer_index 0,1,2,3,0,… then map[0..3]=0,1,2,3; out_valid rises on the first MAP cycle; done=0.
- Reorder: bs=4, write map={2,0,3,1} in FILL, start_i=1 after 4 fills → buffer_index sequence 2,0,3,1,2,…; out_valid=1.
- Drain: bs=4, MAP running, instr_done=1 at MAP cycle 2 → exactly 4 further indices continue the map sequence; then DONE with done=1, out_valid=0, buffer_index frozen.
- Short stream: bs=16, instr_done and start_i both rise after 3 fills → FILL→MAP on that edge, DRAIN next cycle, 16 indices issued, done=1.
- en stall: en=0 for 3 cycles mid-MAP → buffer_index, mp and state unchanged; the sequence resumes exactly on re-enable.
- Illegal write plus reset: map_we=1 in MAP → table unchanged; map_err=1 only with INSTR_MAP_ERR_EN defined. Then rst=0 mid-DRAIN → IDLE, buffer_index=0, done=0, map_err=0, identity table.

Source files
------------

// File: rtl/instr_index_sequencer.sv
// Slot index generator for the instruction buffer: sequential fill, then mapping-table reorder and
// drain. Optional build macro INSTR_MAP_ERR_EN enables the sticky illegal-mapping-write flag.
module instr_index_sequencer #(
  parameter int unsigned bs = 16,
  localparam int unsigned IW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start_i,
  input  logic          instr_done,
  input  logic          map_we,
  input  logic [IW-1:0] map_waddr,
  input  logic [IW-1:0] map_wdata,
  output logic [IW-1:0] buffer_index,
  output logic          out_valid,
  output logic          done,
  output logic          map_err
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StMap,
    StDrain,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] mp_q, mp_d;
  logic [IW-1:0] dc_q, dc_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [IW-1:0] map_q [bs];

  logic          wr_phase;
  logic          in_range;
  logic          map_wr_en;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(bs - 1)) ? '0 : v + 1'b1;
  endfunction

  // Non-power-of-two depths leave encodings that do not name a slot.
  if (bs == (2 ** IW)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (32'(map_waddr) < bs) && (32'(map_wdata) < bs);
  end

  assign wr_phase  = (state_q == StIdle) || (state_q == StFill);
  // Table writes depend only on phase, not on en.
  assign map_wr_en = map_we && wr_phase && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) begin
        map_q[i] <= IW'(i);
      end
    end else if (map_wr_en) begin
      map_q[map_waddr] <= map_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mp_d    = mp_q;
    dc_d    = dc_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (en) begin
      unique case (state_q)
        StIdle: begin
          state_d = StFill;
          idx_d   = wrap_inc(idx_q);
        end
        StFill: begin
          if (start_i) begin
            // instr_done arriving with start_i is seen on the next MAP cycle.
            state_d = StMap;
            idx_d   = map_q[0];
            mp_d    = wrap_inc('0);
            valid_d = 1'b1;
          end else begin
            idx_d = wrap_inc(idx_q);
          end
        end
        StMap: begin
          idx_d   = map_q[mp_q];
          mp_d    = wrap_inc(mp_q);
          valid_d = 1'b1;
          if (instr_done) begin
            state_d = StDrain;
            dc_d    = IW'(bs - 1);
          end
        end
        StDrain: begin
          // The transition edge already issued one index, so bs-1 more follow here.
          if (dc_q == '0) begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = map_q[mp_q];
            mp_d  = wrap_inc(mp_q);
            dc_d  = dc_q - 1'b1;
          end
        end
        StDone: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mp_q    <= '0;
      dc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mp_q    <= mp_d;
      dc_q    <= dc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign buffer_index = idx_q;
  assign out_valid    = valid_q;
  assign done         = done_q;

`ifdef INSTR_MAP_ERR_EN
  logic map_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map_err_q <= 1'b0;
    end else if (map_we && (!wr_phase || !in_range)) begin
      map_err_q <= 1'b1;
    end
  end

  assign map_err = map_err_q;
`else
  assign map_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_index_sequencer.sv
// Directed bench for instr_index_sequencer: a bs=4 instance for most scenarios and a bs=16
// instance for the short-stream drain.
module tb_instr_index_sequencer;

`ifdef INSTR_MAP_ERR_EN
  localparam bit ExpErr = 1'b1;
`else
  localparam bit ExpErr = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // bs = 4 instance
  logic       rst4 = 1'b0, en4 = 1'b1, start4 = 1'b0, idone4 = 1'b0, we4 = 1'b0;
  logic [1:0] waddr4 = '0, wdata4 = '0;
  logic [1:0] bi4;
  logic       ov4, dn4, me4;

  // bs = 16 instance
  logic       rst16 = 1'b0, en16 = 1'b1, start16 = 1'b0, idone16 = 1'b0, we16 = 1'b0;
  logic [3:0] waddr16 = '0, wdata16 = '0;
  logic [3:0] bi16;
  logic       ov16, dn16, me16;

  instr_index_sequencer #(.bs(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst4),
    .en           (en4),
    .start_i      (start4),
    .instr_done   (idone4),
    .map_we       (we4),
    .map_waddr    (waddr4),
    .map_wdata    (wdata4),
    .buffer_index (bi4),
    .out_valid    (ov4),
    .done         (dn4),
    .map_err      (me4)
  );

  instr_index_sequencer #(.bs(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst16),
    .en           (en16),
    .start_i      (start16),
    .instr_done   (idone16),
    .map_we       (we16),
    .map_waddr    (waddr16),
    .map_wdata    (wdata16),
    .buffer_index (bi16),
    .out_valid    (ov16),
    .done         (dn16),
    .map_err      (me16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    rst4 = 1'b0; en4 = 1'b1; start4 = 1'b0; idone4 = 1'b0;
    we4 = 1'b0; waddr4 = '0; wdata4 = '0;
    tick();
    rst4 = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] fill_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] map_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst4 = 1'b0; en4 = 1'b1; start4 = 1'b0; idone4 = 1'b0; we4 = 1'b0;
    tick();
    total++; if (bi4 !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bi4); end
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ov4); end
    total++; if (dn4 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", dn4); end
    total++; if (me4 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", me4); end
    rst4 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bi4 !== fill_seq[i] || ov4 !== 1'b0) begin
        bad++; $display("FAIL reset_fill%0d got=%0d/%b want=%0d/0", i, bi4, ov4, fill_seq[i]);
      end
      tick();
    end
    total++;
    if (bi4 !== 2'd1 || ov4 !== 1'b0) begin
      bad++; $display("FAIL reset_fill_wrap got=%0d/%b want=1/0", bi4, ov4);
    end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total++;
    if (bi4 !== 2'd0 || ov4 !== 1'b1) begin
      bad++; $display("FAIL reset_map_first got=%0d/%b want=0/1", bi4, ov4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bi4 !== map_seq[i] || ov4 !== 1'b1 || dn4 !== 1'b0) begin
        bad++; $display("FAIL reset_map%0d got=%0d/%b/%b want=%0d/1/0", i, bi4, ov4, dn4, map_seq[i]);
      end
    end
  endtask

  task automatic test_reorder();
    logic [1:0] wmap [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic [1:0] fill_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] map_seq [5] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
    reset4();
    we4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waddr4 = 2'(i);
      wdata4 = wmap[i];
      tick();
      total++;
      if (bi4 !== fill_seq[i]) begin
        bad++; $display("FAIL reorder_fill%0d got=%0d want=%0d", i, bi4, fill_seq[i]);
      end
    end
    we4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total++;
    if (bi4 !== 2'd2 || ov4 !== 1'b1) begin
      bad++; $display("FAIL reorder_first got=%0d/%b want=2/1", bi4, ov4);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bi4 !== map_seq[i] || ov4 !== 1'b1) begin
        bad++; $display("FAIL reorder_map%0d got=%0d/%b want=%0d/1", i, bi4, ov4, map_seq[i]);
      end
    end
  endtask

  // Write to map[0] on the FILL->MAP edge: the first index uses the old entry.
  task automatic test_collision();
    logic [1:0] map_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    reset4();
    tick();
    we4 = 1'b1; waddr4 = 2'd0; wdata4 = 2'd3; start4 = 1'b1;
    tick();
    we4 = 1'b0; start4 = 1'b0;
    total++;
    if (bi4 !== 2'd0) begin bad++; $display("FAIL collision_old got=%0d want=0", bi4); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bi4 !== map_seq[i]) begin
        bad++; $display("FAIL collision_map%0d got=%0d want=%0d", i, bi4, map_seq[i]);
      end
    end
  endtask

  task automatic test_drain();
    logic [1:0] wmap [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0] drain_seq [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
    reset4();
    we4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waddr4 = 2'(i);
      wdata4 = wmap[i];
      tick();
    end
    we4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total++;
    if (bi4 !== 2'd3) begin bad++; $display("FAIL drain_map0 got=%0d want=3", bi4); end
    tick();
    total++;
    if (bi4 !== 2'd2) begin bad++; $display("FAIL drain_map1 got=%0d want=2", bi4); end
    idone4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bi4 !== drain_seq[i] || ov4 !== 1'b1 || dn4 !== 1'b0) begin
        bad++;
        $display("FAIL drain_idx%0d got=%0d/%b/%b want=%0d/1/0", i, bi4, ov4, dn4, drain_seq[i]);
      end
    end
    tick();
    total++;
    if (bi4 !== 2'd2 || ov4 !== 1'b0 || dn4 !== 1'b1) begin
      bad++; $display("FAIL drain_done got=%0d/%b/%b want=2/0/1", bi4, ov4, dn4);
    end
    start4 = 1'b1;
    idone4 = 1'b0;
    tick();
    tick();
    start4 = 1'b0;
    total++;
    if (bi4 !== 2'd2 || ov4 !== 1'b0 || dn4 !== 1'b1) begin
      bad++; $display("FAIL drain_hold got=%0d/%b/%b want=2/0/1", bi4, ov4, dn4);
    end
  endtask

  task automatic test_en_stall();
    logic [1:0] resume_seq [3] = '{2'd2, 2'd3, 2'd0};
    reset4();
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    total++;
    if (bi4 !== 2'd1) begin bad++; $display("FAIL stall_pre got=%0d want=1", bi4); end
    en4 = 1'b0;
    idone4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bi4 !== 2'd1 || ov4 !== 1'b1 || dn4 !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got=%0d/%b/%b want=1/1/0", i, bi4, ov4, dn4);
      end
    end
    idone4 = 1'b0;
    en4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bi4 !== resume_seq[i] || ov4 !== 1'b1) begin
        bad++; $display("FAIL stall_resume%0d got=%0d/%b want=%0d/1", i, bi4, ov4, resume_seq[i]);
      end
    end
  endtask

  task automatic test_illegal_write();
    logic [1:0] wmap [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] id_seq [3] = '{2'd1, 2'd2, 2'd3};
    reset4();
    we4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waddr4 = 2'(i);
      wdata4 = wmap[i];
      tick();
    end
    we4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total++;
    if (bi4 !== 2'd1) begin bad++; $display("FAIL illegal_map0 got=%0d want=1", bi4); end
    we4 = 1'b1; waddr4 = 2'd2; wdata4 = 2'd0;
    tick();
    we4 = 1'b0;
    total++;
    if (bi4 !== 2'd2) begin bad++; $display("FAIL illegal_map1 got=%0d want=2", bi4); end
    total++;
    if (me4 !== ExpErr) begin bad++; $display("FAIL illegal_err got=%b want=%b", me4, ExpErr); end
    tick();
    total++;
    if (bi4 !== 2'd3) begin bad++; $display("FAIL illegal_unchanged got=%0d want=3", bi4); end
    idone4 = 1'b1;
    tick();
    tick();
    total++;
    if (bi4 !== 2'd1 || ov4 !== 1'b1) begin
      bad++; $display("FAIL illegal_drain got=%0d/%b want=1/1", bi4, ov4);
    end
    rst4 = 1'b0;
    #1;
    total++;
    if (bi4 !== 2'd0 || ov4 !== 1'b0 || dn4 !== 1'b0 || me4 !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b/%b/%b want=0/0/0/0", bi4, ov4, dn4, me4);
    end
    idone4 = 1'b0;
    rst4 = 1'b1;
    tick();
    total++;
    if (bi4 !== 2'd1) begin bad++; $display("FAIL reset_refill got=%0d want=1", bi4); end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total++;
    if (bi4 !== 2'd0) begin bad++; $display("FAIL identity_map0 got=%0d want=0", bi4); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bi4 !== id_seq[i]) begin
        bad++; $display("FAIL identity_map%0d got=%0d want=%0d", i + 1, bi4, id_seq[i]);
      end
    end
  endtask

  task automatic test_short_stream();
    logic [3:0] exp_idx;
    rst16 = 1'b0;
    tick();
    rst16 = 1'b1;
    total++;
    if (bi16 !== 4'd0 || dn16 !== 1'b0) begin
      bad++; $display("FAIL short_reset got=%0d/%b want=0/0", bi16, dn16);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_idx = 4'(i);
      total++;
      if (bi16 !== exp_idx) begin
        bad++; $display("FAIL short_fill%0d got=%0d want=%0d", i, bi16, exp_idx);
      end
    end
    start16 = 1'b1;
    idone16 = 1'b1;
    tick();
    start16 = 1'b0;
    total++;
    if (bi16 !== 4'd0 || ov16 !== 1'b1 || dn16 !== 1'b0) begin
      bad++; $display("FAIL short_map got=%0d/%b/%b want=0/1/0", bi16, ov16, dn16);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_idx = 4'((k + 1) % 16);
      total++;
      if (bi16 !== exp_idx || ov16 !== 1'b1 || dn16 !== 1'b0) begin
        bad++;
        $display("FAIL short_drain%0d got=%0d/%b/%b want=%0d/1/0", k, bi16, ov16, dn16, exp_idx);
      end
    end
    tick();
    total++;
    if (bi16 !== 4'd0 || ov16 !== 1'b0 || dn16 !== 1'b1) begin
      bad++; $display("FAIL short_done got=%0d/%b/%b want=0/0/1", bi16, ov16, dn16);
    end
    total++;
    if (me16 !== 1'b0) begin bad++; $display("FAIL short_err got=%b want=0", me16); end
  endtask

  initial begin
    test_reset();
    test_reorder();
    test_collision();
    test_drain();
    test_en_stall();
    test_illegal_write();
    test_short_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
